// File: rtl/draw_cursor_pkg.sv
// Shared definitions for the draw stages: timing-bundle widths, colour
// width, default active-area size, the transparent colour key and the
// cursor sprite image used by the cursor ROM.
package draw_cursor_pkg;

  localparam int RGB_W  = 12;
  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int POS_W  = 12;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;

  localparam logic [RGB_W-1:0] TRANSPARENT_DEF = 12'hF0F;
  localparam logic [RGB_W-1:0] CUR_EDGE_RGB    = 12'h0F0;
  localparam logic [RGB_W-1:0] CUR_FILL_RGB    = 12'hFFF;
  localparam logic [RGB_W-1:0] BLANK_RGB       = 12'h000;

  // Timing bundle carried alongside every pixel through the draw stages.
  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              hblnk;
    logic              vblnk;
    logic              hsync;
    logic              vsync;
  } timing_t;

  // Saturate a mouse coordinate to the last visible pixel/line.
  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] pos,
                                                 input logic [POS_W-1:0] lim);
    logic [POS_W-1:0] res;
    if (pos > lim) begin
      res = lim;
    end else begin
      res = pos;
    end
    return res;
  endfunction

  // Sprite image: a left-aligned arrow. Pixels right of the diagonal are
  // the colour key, the left column, the diagonal and the bottom row form
  // the outline, and the remainder is the fill colour.
  function automatic logic [RGB_W-1:0] cursor_pixel(input int row,
                                                    input int col,
                                                    input int last_row);
    logic [RGB_W-1:0] pix;
    if (col > row) begin
      pix = TRANSPARENT_DEF;
    end else if ((col == 0) || (col == row) || (row == last_row)) begin
      pix = CUR_EDGE_RGB;
    end else begin
      pix = CUR_FILL_RGB;
    end
    return pix;
  endfunction

endpackage

// File: rtl/draw_cursor_rom.sv
// Cursor sprite ROM: CUR_W*CUR_H words of 12-bit colour, addressed as
// {row, column}. Read is synchronous with one cycle of latency.
module draw_cursor_rom
  import draw_cursor_pkg::*;
#(
  parameter int CUR_W = 16,
  parameter int CUR_H = 16,
  localparam int AX = $clog2(CUR_W),
  localparam int AY = $clog2(CUR_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AX+AY-1:0]   i_addr,
  output logic [RGB_W-1:0]   o_data
);

  logic [AY-1:0]    w_row;
  logic [AX-1:0]    w_col;
  logic [RGB_W-1:0] r_data;

  assign w_row  = i_addr[AX+AY-1:AX];
  assign w_col  = i_addr[AX-1:0];
  assign o_data = r_data;

  // Registered read of the sprite image at the requested address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= 12'h000;
    end else begin
      r_data <= cursor_pixel(int'(w_row), int'(w_col), CUR_H - 1);
    end
  end

endmodule

// File: rtl/draw_cursor.sv
// Mouse-cursor overlay stage. Latches the mouse position once per frame on
// the vblank rising edge, decides per pixel whether it lies inside the
// cursor window, and composites the sprite over the background through a
// two-cycle pipeline that also delays the timing bundle.
module draw_cursor
  import draw_cursor_pkg::*;
#(
  parameter int                 CUR_W       = 16,
  parameter int                 CUR_H       = 16,
  parameter int                 H_ACTIVE    = H_ACTIVE_DEF,
  parameter int                 V_ACTIVE    = V_ACTIVE_DEF,
  parameter logic [RGB_W-1:0]   TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [HCNT_W-1:0]  hcount_in,
  input  logic [VCNT_W-1:0]  vcount_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [POS_W-1:0]   xpos_in,
  input  logic [POS_W-1:0]   ypos_in,
  output logic [HCNT_W-1:0]  hcount_out,
  output logic [VCNT_W-1:0]  vcount_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [RGB_W-1:0]   rgb_out
);

  localparam int AX = $clog2(CUR_W);
  localparam int AY = $clog2(CUR_H);

  localparam logic [POS_W-1:0] X_LIM  = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] Y_LIM  = POS_W'(V_ACTIVE - 1);
  localparam logic [POS_W-1:0] WIN_W  = POS_W'(CUR_W);
  localparam logic [POS_W-1:0] WIN_H  = POS_W'(CUR_H);

  // Frame-stable cursor position
  logic             r_vblnk_d;
  logic [POS_W-1:0] r_x_frm;
  logic [POS_W-1:0] r_y_frm;
  logic             w_frame_edge;

  // Window test (stage 0, combinational)
  logic [POS_W-1:0] w_h12;
  logic [POS_W-1:0] w_v12;
  logic [POS_W-1:0] w_dx;
  logic [POS_W-1:0] w_dy;
  logic             w_in_win;
  logic [AX+AY-1:0] w_addr;
  timing_t          w_tim;

  // Stage 1
  logic             r_in_win;
  logic [RGB_W-1:0] r_rgb;
  timing_t          r_tim;
  logic [RGB_W-1:0] w_rom_data;

  // Stage 2 colour select
  logic [RGB_W-1:0] w_rgb_next;

  assign w_frame_edge = vblnk_in & ~r_vblnk_d;

  // Arithmetic is done on 12 bits so the counters compare directly with
  // the mouse coordinates; pixels left of/above the cursor wrap to large
  // dx/dy and are rejected by the >= terms.
  assign w_h12    = {1'b0, hcount_in};
  assign w_v12    = {2'b00, vcount_in};
  assign w_dx     = w_h12 - r_x_frm;
  assign w_dy     = w_v12 - r_y_frm;
  assign w_in_win = (w_h12 >= r_x_frm) && (w_dx < WIN_W) &&
                    (w_v12 >= r_y_frm) && (w_dy < WIN_H);
  assign w_addr   = {w_dy[AY-1:0], w_dx[AX-1:0]};

  assign w_tim = '{hcount: hcount_in, vcount: vcount_in,
                   hblnk: hblnk_in, vblnk: vblnk_in,
                   hsync: hsync_in, vsync: vsync_in};

  // Sample the mouse position only at the start of vertical blanking so a
  // frame is always drawn with a single cursor position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d <= 1'b0;
      r_x_frm   <= 12'h000;
      r_y_frm   <= 12'h000;
    end else begin
      r_vblnk_d <= vblnk_in;
      if (w_frame_edge) begin
        r_x_frm <= clamp_pos(xpos_in, X_LIM);
        r_y_frm <= clamp_pos(ypos_in, Y_LIM);
      end else begin
        r_x_frm <= r_x_frm;
        r_y_frm <= r_y_frm;
      end
    end
  end

  // The ROM registers its read internally, so its data lines up with the
  // stage-1 registers below.
  draw_cursor_rom #(
    .CUR_W (CUR_W),
    .CUR_H (CUR_H)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .i_addr (w_addr),
    .o_data (w_rom_data)
  );

  // Stage 1: hold window flag, background colour and timing while the ROM reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_win <= 1'b0;
      r_rgb    <= 12'h000;
      r_tim    <= '{hcount: 11'd0, vcount: 10'd0, hblnk: 1'b0,
                    vblnk: 1'b0, hsync: 1'b0, vsync: 1'b0};
    end else begin
      r_in_win <= w_in_win;
      r_rgb    <= rgb_in;
      r_tim    <= w_tim;
    end
  end

  // Blanking wins over everything, which also clips a cursor hanging off
  // the right or bottom edge; the colour key lets the background show through.
  always_comb begin
    w_rgb_next = r_rgb;
    if (r_tim.hblnk || r_tim.vblnk) begin
      w_rgb_next = BLANK_RGB;
    end else if (r_in_win && (w_rom_data != TRANSPARENT)) begin
      w_rgb_next = w_rom_data;
    end else begin
      w_rgb_next = r_rgb;
    end
  end

  // Stage 2: registered outputs, colour aligned with the delayed timing bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 10'd0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= r_tim.hcount;
      vcount_out <= r_tim.vcount;
      hblnk_out  <= r_tim.hblnk;
      vblnk_out  <= r_tim.vblnk;
      hsync_out  <= r_tim.hsync;
      vsync_out  <= r_tim.vsync;
      rgb_out    <= w_rgb_next;
    end
  end

endmodule
